// File: rtl/gf2m8_arith_unit.sv
// GF(2^8) arithmetic primitive (poly 0x11D): comb multiplier z=x*y, comb
// inverter b_inv=b^254 (0 for b=0), latch ICG gclk, and result regs q_z/q_inv.
// Ports: clk, rst (sync, active-high), ena (gate enable), x, y, b in;
//        z, b_inv, gclk, q_z, q_inv out.
module gf2m8_arith_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] b,
  output logic [7:0] z,
  output logic [7:0] b_inv,
  output logic       gclk,
  output logic [7:0] q_z,
  output logic [7:0] q_inv
);

  // Carry-less 15-bit product, then fold the high bits down with 0x11D.
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] c
  );
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) p = p ^ (15'h11D << (i - 8));
    end
    return p[7:0];
  endfunction

  // b^254 = b^2 * b^4 * ... * b^128; b=0 falls out as 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] v);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = v;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic       en_l;
  logic [7:0] q_z_q, q_z_d;
  logic [7:0] q_inv_q, q_inv_d;

  assign z     = gf_mul(x, y);
  assign b_inv = gf_inv(b);

  // Enable latch is transparent only while clk is low, so gclk
  // can never be chopped mid-pulse. rst forces the gate open.
  always_latch begin
    if (!clk) en_l <= ena | rst;
  end

  assign gclk = clk & en_l;

  always_comb begin
    q_z_d   = z;
    q_inv_d = b_inv;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      q_z_q   <= 8'h00;
      q_inv_q <= 8'h00;
    end else begin
      q_z_q   <= q_z_d;
      q_inv_q <= q_inv_d;
    end
  end

  assign q_z   = q_z_q;
  assign q_inv = q_inv_q;

endmodule

// File: tb/tb_gf2m8_arith_unit.sv
// Bench for gf2m8_arith_unit: directed steps with a scoreboard queue of
// expected values, compared by immediate assertions.
module tb_gf2m8_arith_unit;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] b;
  logic [7:0] z;
  logic [7:0] b_inv;
  logic       gclk;
  logic [7:0] q_z;
  logic [7:0] q_inv;

  gf2m8_arith_unit dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .x     (x),
    .y     (y),
    .b     (b),
    .z     (z),
    .b_inv (b_inv),
    .gclk  (gclk),
    .q_z   (q_z),
    .q_inv (q_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int gclk_cnt = 0;
  always @(posedge gclk) gclk_cnt++;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Shift-and-add reference: each bit-7 overflow folds in 0x1D.
  function automatic logic [7:0] ref_mul(
    input logic [7:0] a,
    input logic [7:0] c
  );
    logic [7:0] r;
    logic [7:0] s;
    logic       cy;
    r = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) r = r ^ s;
      cy = s[7];
      s  = s << 1;
      if (cy) s = s ^ 8'h1D;
    end
    return r;
  endfunction

  // Brute-force inverse by search.
  function automatic logic [7:0] ref_inv(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 1; k < 256; k++) begin
      if (ref_mul(v, 8'(k)) == 8'h01) r = 8'(k);
    end
    return r;
  endfunction

  task automatic push(input string tag, input logic [7:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    sb_t s;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%02h expected=entry", obs);
    end else begin
      s = sbq.pop_front();
      assert (obs === s.exp) else begin
        n_err++;
        $error("FAIL %s observed=%02h expected=%02h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic drive_low();
    @(negedge clk);
    #1;
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] inv_tab [256];
  int         c0;

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    x   = 8'h00;
    y   = 8'h00;
    b   = 8'h00;
    for (int k = 0; k < 256; k++) inv_tab[k] = ref_inv(8'(k));

    // Reset
    after_rise();
    after_rise();
    push("rst_q_z", 8'h00);
    push("rst_q_inv", 8'h00);
    pop_check(q_z);
    pop_check(q_inv);
    drive_low();
    rst = 1'b0;

    // Directed multiplier vectors
    x = 8'h80; y = 8'h80; push("mul_80_80", 8'h13); #1; pop_check(z);
    x = 8'hB9; y = 8'hB9; push("mul_b9_b9", 8'h3B); #1; pop_check(z);
    x = 8'h02; y = 8'h80; push("mul_02_80", 8'h1D); #1; pop_check(z);
    x = 8'h80; y = 8'h02; push("mul_80_02", 8'h1D); #1; pop_check(z);
    x = 8'h5A; y = 8'h00; push("mul_x0", 8'h00); #1; pop_check(z);
    x = 8'h5A; y = 8'h01; push("mul_x1", 8'h5A); #1; pop_check(z);

    // Directed inverter vectors
    b = 8'h02; push("inv_02", 8'h8E); #1; pop_check(b_inv);
    b = 8'h01; push("inv_01", 8'h01); #1; pop_check(b_inv);
    b = 8'h00; push("inv_00", 8'h00); #1; pop_check(b_inv);

    // Exhaustive multiplier against the shift-xor model
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        x = 8'(i);
        y = 8'(j);
        push("mul_exh", ref_mul(8'(i), 8'(j)));
        #1;
        pop_check(z);
      end
    end

    // Exhaustive inverter: b*b^-1 must be 1
    for (int i = 1; i < 256; i++) begin
      b = 8'(i);
      push("inv_exh", inv_tab[i]);
      #1;
      pop_check(b_inv);
      push("inv_prod", 8'h01);
      pop_check(ref_mul(8'(i), b_inv));
    end

    // Gated register capture
    drive_low();
    ena = 1'b1;
    x = 8'h80; y = 8'h80; b = 8'h02;
    push("cap_q_z", 8'h13);
    push("cap_q_inv", 8'h8E);
    after_rise();
    pop_check(q_z);
    pop_check(q_inv);

    // Gate closed: inputs wiggle, registers and gclk stay put
    drive_low();
    ena = 1'b0;
    c0 = gclk_cnt;
    for (int k = 0; k < 5; k++) begin
      x = 8'(k * 37 + 1);
      y = 8'(k * 11 + 3);
      b = 8'(k + 5);
      push("hold_q_z", 8'h13);
      push("hold_gclk", 8'h00);
      after_rise();
      pop_check(q_z);
      pop_check({7'b0, gclk});
      drive_low();
    end
    push("hold_edges", 8'h00);
    pop_check(8'(gclk_cnt - c0));

    // Reset with gate closed still clears
    rst = 1'b1;
    push("rst2_q_z", 8'h00);
    push("rst2_q_inv", 8'h00);
    after_rise();
    pop_check(q_z);
    pop_check(q_inv);
    drive_low();
    rst = 1'b0;

    // Reset beats enable
    ena = 1'b1;
    rst = 1'b1;
    x = 8'h80; y = 8'h80;
    push("rst_ena_q_z", 8'h00);
    after_rise();
    pop_check(q_z);
    drive_low();
    rst = 1'b0;
    ena = 1'b0;

    // Enable raised while clk high: no partial pulse
    x = 8'h02; y = 8'h80;
    @(posedge clk);
    c0 = gclk_cnt;
    #2;
    ena = 1'b1;
    #1;
    push("glitch_rise_gclk", 8'h00);
    pop_check({7'b0, gclk});
    @(negedge clk);
    #1;
    push("glitch_rise_edges", 8'h00);
    pop_check(8'(gclk_cnt - c0));
    push("glitch_rise_q_z", 8'h00);
    pop_check(q_z);
    push("glitch_next_q_z", 8'h1D);
    after_rise();
    pop_check(q_z);

    // Enable dropped while clk high: pulse not truncated
    #1;
    ena = 1'b0;
    #1;
    push("glitch_fall_gclk", 8'h01);
    pop_check({7'b0, gclk});
    drive_low();
    x = 8'h80; y = 8'h80;
    c0 = gclk_cnt;
    push("glitch_fall_q_z", 8'h1D);
    push("glitch_fall_edges", 8'h00);
    after_rise();
    pop_check(q_z);
    pop_check(8'(gclk_cnt - c0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
